pipe_irq_source: RTL and testbench

//  Interrupt request source for the pipeline CPU: produces the 2-bit interrupt input the core samples.

---
 rtl/pipe_irq_pkg.sv | 9 +
 rtl/irq_edge_sync.sv | 29 ++
 rtl/pipe_irq_source.sv | 104 ++++++++++
 tb/tb_pipe_irq_source.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_irq_pkg.sv
// pipe_irq_pkg: shared types and helpers for the pipeline interrupt source
package pipe_irq_pkg;
  localparam int NUM_IRQ = 2;
  localparam int IRQ_ID_W = 1;
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IRQ_ID_W-1:0] id);
    return NUM_IRQ'(1) << id;
  endfunction
endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: synchronizes one async event line and emits a registered one-cycle rising-edge pulse
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, evt_q, evt_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    evt_d  = sync_q[SYNC_STAGES-1] & ~prev_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end
  assign evt = evt_q;
endmodule

// File: rtl/pipe_irq_source.sv
// pipe_irq_source: latches external/timer events as pending and presents one request at a time to the core
module pipe_irq_source
  import pipe_irq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMER_WIDTH  = 16,
  parameter int TIMER_PERIOD = 1000,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                clk_gl,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  ext_evt,
  input  logic                timer_en,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                irq_ack,
  input  logic [IRQ_ID_W-1:0] ack_id,
  input  logic                clr_flags,
  output logic [NUM_IRQ-1:0]  interrupt,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  overflow,
  output logic                ack_err
);
  localparam int CW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  logic [NUM_IRQ-1:0] evt, ev, req, clr_vec;
  logic [NUM_IRQ-1:0] pending_q, pending_d, overflow_q, overflow_d, int_q, int_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [IRQ_ID_W-1:0] cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ack_err_q, ack_err_d, tick, ack_ok;
  state_t state_q, state_d;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk_gl),
      .rst(rst),
      .din(ext_evt[i]),
      .evt(evt[i])
    );
  end
  // A matching ack and a new event on the same line keep the line pending without flagging overflow.
  always_comb begin
    tick       = timer_en && timer_q == TIMER_WIDTH'(TIMER_PERIOD - 1);
    timer_d    = timer_en && !tick ? timer_q + 1'b1 : '0;
    ev         = evt | NUM_IRQ'(tick);
    ack_ok     = irq_ack && state_q == REQ && ack_id == cur_q;
    clr_vec    = ack_ok ? onehot(cur_q) : '0;
    pending_d  = ev | (pending_q & ~clr_vec);
    overflow_d = (ev & pending_q & ~clr_vec) | (clr_flags ? '0 : overflow_q);
    ack_err_d  = (irq_ack && !ack_ok) || (!clr_flags && ack_err_q);
  end
  always_ff @(posedge clk_gl or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      int_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      int_q      <= int_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
    end
  end
  always_comb begin
    req     = pending_q & irq_mask;
    state_d = state_q;
    cur_d   = cur_q;
    int_d   = int_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        cur_d   = req[0] ? '0 : IRQ_ID_W'(1);
        int_d   = onehot(cur_d);
        state_d = REQ;
      end
      REQ: if (ack_ok) begin
        int_d   = '0;
        cnt_d   = CW'(GAP_CYCLES);
        state_d = GAP_CYCLES == 0 ? IDLE : GAP;
      end else if (!irq_mask[cur_q]) begin
        int_d   = '0;
        state_d = IDLE;
      end
      GAP: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    interrupt = int_q;
    pending   = pending_q;
    overflow  = overflow_q;
    ack_err   = ack_err_q;
  end
endmodule

// File: tb/tb_pipe_irq_source.sv
// tb_pipe_irq_source: directed stimulus with a queue of expected request presentations checked by a monitor
module tb_pipe_irq_source;
  logic clk_gl = 1'b0, rst = 1'b0;
  logic [1:0] ext_evt = '0, irq_mask = 2'b11;
  logic timer_en = 1'b0, irq_ack = 1'b0, ack_id = 1'b0, clr_flags = 1'b0;
  logic [1:0] interrupt, pending, overflow;
  logic ack_err;
  int vectors = 0, miscompares = 0, cyc = 0, t0 = 0;
  typedef struct {logic [1:0] v; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [1:0] prev_int = '0;

  pipe_irq_source #(.SYNC_STAGES(2), .TIMER_WIDTH(16), .TIMER_PERIOD(1000), .GAP_CYCLES(4)) dut (
    .clk_gl(clk_gl), .rst(rst), .ext_evt(ext_evt), .timer_en(timer_en), .irq_mask(irq_mask),
    .irq_ack(irq_ack), .ack_id(ack_id), .clr_flags(clr_flags), .interrupt(interrupt),
    .pending(pending), .overflow(overflow), .ack_err(ack_err)
  );

  always #5 clk_gl = ~clk_gl;
  always @(posedge clk_gl) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_gl);
    #1;
  endtask

  task automatic wait_for(input logic [1:0] v, input int budget);
    int n = 0;
    while (interrupt !== v && n < budget) begin
      @(negedge clk_gl);
      n++;
    end
    if (interrupt !== v) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_irq: got %0h want %0h at cycle %0d", interrupt, v, cyc);
    end
  endtask

  task automatic ack(input logic id);
    irq_ack = 1'b1;
    ack_id  = id;
    step();
    irq_ack = 1'b0;
  endtask

  // Every new presentation (0 -> nonzero) must match the next queued value and cycle.
  always @(negedge clk_gl) begin
    if (!rst && interrupt != 2'b00 && prev_int == 2'b00) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_irq: got %0h want none at cycle %0d", interrupt, cyc);
      end else begin
        e = q.pop_front();
        chk("irq_value", interrupt, e.v);
        chk("irq_cycle", cyc, e.c);
      end
    end
    prev_int = interrupt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_interrupt", interrupt, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ack_err", ack_err, 0);
    step(2);
    rst = 1'b0;
    step(2);
    // reset while a request is being presented
    ext_evt = 2'b01;
    q.push_back('{2'b01, cyc + 5});
    step(3);
    ext_evt = 2'b00;
    wait_for(2'b01, 20);
    #2 rst = 1'b1;
    #1;
    chk("midreq_rst_interrupt", interrupt, 0);
    chk("midreq_rst_pending", pending, 0);
    step();
    rst = 1'b0;
    step(15);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_interrupt", interrupt, 0);
    // line 1 request, line 0 arrives during REQ without preempting
    ext_evt = 2'b10;
    q.push_back('{2'b10, cyc + 5});
    step(3);
    wait_for(2'b10, 20);
    step();
    ext_evt = 2'b01;
    step(6);
    chk("no_preempt", interrupt, 2'b10);
    chk("pend_both", pending, 2'b11);
    q.push_back('{2'b01, cyc + 6});
    ack(1'b1);
    chk("ack1_int_clear", interrupt, 0);
    chk("ack1_pend", pending, 2'b01);
    ext_evt = 2'b00;
    wait_for(2'b01, 20);
    ack(1'b0);
    step(8);
    chk("t2_pend_clear", pending, 0);
    chk("t2_no_ack_err", ack_err, 0);
    // both lines together: line 0 first, then line 1 after the gap
    ext_evt = 2'b11;
    q.push_back('{2'b01, cyc + 5});
    step(3);
    ext_evt = 2'b00;
    wait_for(2'b01, 20);
    step();
    q.push_back('{2'b10, cyc + 6});
    ack(1'b0);
    wait_for(2'b10, 20);
    step();
    ack(1'b1);
    step(8);
    chk("t3_pend_clear", pending, 0);
    chk("t3_no_ack_err", ack_err, 0);
    // acknowledge errors
    ack(1'b0);
    chk("ack_idle_err", ack_err, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_ack_err", ack_err, 0);
    ext_evt = 2'b01;
    q.push_back('{2'b01, cyc + 5});
    step(3);
    ext_evt = 2'b00;
    wait_for(2'b01, 20);
    step();
    ack(1'b1);
    chk("wrong_id_err", ack_err, 1);
    chk("wrong_id_hold", interrupt, 2'b01);
    chk("wrong_id_pend", pending, 2'b01);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_ack_err2", ack_err, 0);
    irq_ack = 1'b1;
    ack_id = 1'b1;
    clr_flags = 1'b1;
    step();
    irq_ack = 1'b0;
    clr_flags = 1'b0;
    chk("set_beats_clr", ack_err, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_ack_err3", ack_err, 0);
    // mask drop during REQ and restore
    irq_mask = 2'b10;
    step();
    chk("mask_drop_int", interrupt, 0);
    chk("mask_drop_pend", pending, 2'b01);
    step(3);
    chk("masked_idle_int", interrupt, 0);
    irq_mask = 2'b11;
    q.push_back('{2'b01, cyc + 1});
    step();
    wait_for(2'b01, 5);
    step();
    ack(1'b0);
    step(8);
    chk("t6_pend_clear", pending, 0);
    // periodic timer: first tick, then overflow on second tick
    timer_en = 1'b1;
    t0 = cyc;
    q.push_back('{2'b01, t0 + 1001});
    while (cyc < t0 + 999) step();
    chk("timer_pre_tick", pending, 0);
    step();
    chk("timer_tick_pend", pending, 2'b01);
    while (cyc < t0 + 1999) step();
    chk("timer_pre_ovf", overflow, 0);
    step();
    chk("timer_ovf", overflow, 2'b01);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_cleared", overflow, 0);
    timer_en = 1'b0;
    ack(1'b0);
    step(8);
    chk("timer_pend_clear", pending, 0);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
